// File: rtl/fm_nco_multi.sv
// Multi-channel phase-accumulator square-wave generator with wrap-aligned tuning word updates.
// Optional burst mode (per-channel wrap counter with auto-stop) is enabled by defining FM_BURST_EN.
module fm_nco_multi #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 32,
  parameter int CH_W     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [CH_W-1:0]     i_ch,
  input  logic [ACC_W-1:0]    i_tw,
  input  logic [CHANNELS-1:0] i_en,
`ifdef FM_BURST_EN
  input  logic [15:0]         i_burst,
  output logic [CHANNELS-1:0] o_done,
`endif
  output logic [CHANNELS-1:0] o_clk,
  output logic [CHANNELS-1:0] o_pend,
  output logic [CHANNELS-1:0] o_wrap
);

  logic [ACC_W-1:0]    acc_q    [CHANNELS];
  logic [ACC_W-1:0]    acc_d    [CHANNELS];
  logic [ACC_W-1:0]    tw_act_q [CHANNELS];
  logic [ACC_W-1:0]    tw_act_d [CHANNELS];
  logic [ACC_W-1:0]    tw_pend_q[CHANNELS];
  logic [ACC_W-1:0]    tw_pend_d[CHANNELS];
  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] wrap_q, wrap_d;

`ifdef FM_BURST_EN
  logic [15:0]         cnt_q   [CHANNELS];
  logic [15:0]         cnt_d   [CHANNELS];
  logic [15:0]         bpend_q [CHANNELS];
  logic [15:0]         bpend_d [CHANNELS];
  logic [CHANNELS-1:0] stop_q, stop_d;
  logic [CHANNELS-1:0] done_q, done_d;
`endif

  always_comb begin
    logic [ACC_W:0] sum;
    logic           apply;
    logic           carry;
    sum       = '0;
    apply     = 1'b0;
    carry     = 1'b0;
    acc_d     = acc_q;
    tw_act_d  = tw_act_q;
    tw_pend_d = tw_pend_q;
    clk_d     = clk_q;
    pend_d    = pend_q;
    wrap_d    = '0;
`ifdef FM_BURST_EN
    cnt_d     = cnt_q;
    bpend_d   = bpend_q;
    stop_d    = stop_q;
    done_d    = '0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      sum   = {1'b0, acc_q[c]} + {1'b0, tw_act_q[c]};
      carry = 1'b0;
      apply = 1'b0;
      if (i_en[c]) begin
`ifdef FM_BURST_EN
        if (stop_q[c]) begin
          // A stopped channel never wraps, so a pending word restarts it directly.
          apply = pend_q[c];
        end else begin
`endif
          carry     = sum[ACC_W];
          acc_d[c]  = sum[ACC_W-1:0];
          clk_d[c]  = sum[ACC_W-1];
          wrap_d[c] = carry;
          // A zero active word never wraps, so it must not block the update.
          apply     = pend_q[c] && (carry || (tw_act_q[c] == '0));
`ifdef FM_BURST_EN
        end
`endif
        if (apply) begin
          tw_act_d[c] = tw_pend_q[c];
          pend_d[c]   = 1'b0;
        end
`ifdef FM_BURST_EN
        if (apply) begin
          cnt_d[c]  = bpend_q[c];
          stop_d[c] = 1'b0;
        end else if (carry && (cnt_q[c] != '0)) begin
          cnt_d[c] = cnt_q[c] - 16'd1;
          if (cnt_q[c] == 16'd1) begin
            stop_d[c] = 1'b1;
            acc_d[c]  = '0;
            clk_d[c]  = 1'b0;
            done_d[c] = 1'b1;
          end
        end
`endif
      end
      // Load is evaluated after apply so a same-edge load becomes the next pending word.
      if (i_load && (int'(i_ch) == c)) begin
        tw_pend_d[c] = i_tw;
        pend_d[c]    = 1'b1;
`ifdef FM_BURST_EN
        bpend_d[c]   = i_burst;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]     <= '0;
        tw_act_q[c]  <= '0;
        tw_pend_q[c] <= '0;
      end
      clk_q  <= '0;
      pend_q <= '0;
      wrap_q <= '0;
    end else begin
      acc_q     <= acc_d;
      tw_act_q  <= tw_act_d;
      tw_pend_q <= tw_pend_d;
      clk_q     <= clk_d;
      pend_q    <= pend_d;
      wrap_q    <= wrap_d;
    end
  end

`ifdef FM_BURST_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]   <= '0;
        bpend_q[c] <= '0;
      end
      stop_q <= '0;
      done_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      bpend_q <= bpend_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  assign o_done = done_q;
`endif

  assign o_clk  = clk_q;
  assign o_pend = pend_q;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_fm_nco_multi.sv
// Scoreboard bench for fm_nco_multi (4 channels, 16-bit accumulator, default build).
module tb_fm_nco_multi;

  localparam int CHANNELS = 4;
  localparam int ACC_W    = 16;
  localparam int CH_W     = 2;
  localparam int MODULUS  = 65536;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b0;
  logic                i_load = 1'b0;
  logic [CH_W-1:0]     i_ch = '0;
  logic [ACC_W-1:0]    i_tw = '0;
  logic [CHANNELS-1:0] i_en = '0;
  logic [CHANNELS-1:0] o_clk, o_pend, o_wrap;

  fm_nco_multi #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .CH_W(CH_W)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (i_load),
    .i_ch   (i_ch),
    .i_tw   (i_tw),
    .i_en   (i_en),
    .o_clk  (o_clk),
    .o_pend (o_pend),
    .o_wrap (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [CHANNELS-1:0] clk;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] wrap;
    int                  id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_steps = 0;

  // Reference model: phase as an integer, frequency word applied when phase passes 2^ACC_W.
  int unsigned         m_phase [CHANNELS];
  int unsigned         m_word  [CHANNELS];
  int unsigned         m_next  [CHANNELS];
  bit                  m_wait  [CHANNELS];
  logic [CHANNELS-1:0] m_clk, m_wrap;

  function automatic void model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_phase[c] = 0;
      m_word[c]  = 0;
      m_next[c]  = 0;
      m_wait[c]  = 0;
    end
    m_clk  = '0;
    m_wrap = '0;
  endfunction

  task automatic step(input bit ld, input int ch, input int unsigned tw, input logic [CHANNELS-1:0] en);
    exp_t        e;
    int unsigned total;
    bit          wrapped;
    @(negedge i_clk);
    i_load = ld;
    i_ch   = CH_W'(ch);
    i_tw   = ACC_W'(tw);
    i_en   = en;
    for (int c = 0; c < CHANNELS; c++) begin
      m_wrap[c] = 1'b0;
      if (en[c]) begin
        total      = m_phase[c] + m_word[c];
        wrapped    = (total >= MODULUS);
        m_phase[c] = total % MODULUS;
        m_clk[c]   = (m_phase[c] >= MODULUS / 2);
        m_wrap[c]  = wrapped;
        if (m_wait[c] && (wrapped || m_word[c] == 0)) begin
          m_word[c] = m_next[c];
          m_wait[c] = 0;
        end
      end
    end
    if (ld && ch < CHANNELS) begin
      m_next[ch] = tw;
      m_wait[ch] = 1;
    end
    e.clk  = m_clk;
    e.wrap = m_wrap;
    for (int c = 0; c < CHANNELS; c++) e.pend[c] = m_wait[c];
    e.id = n_steps;
    n_steps++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [CHANNELS-1:0] en);
    for (int i = 0; i < n; i++) step(0, 0, 0, en);
  endtask

  task automatic check_vec(input string name, input logic [CHANNELS-1:0] act, input logic [CHANNELS-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_load = 0;
    i_en   = '0;
    i_rst  = 1;
    #1;
    check_vec("reset_o_clk", o_clk, '0);
    check_vec("reset_o_pend", o_pend, '0);
    check_vec("reset_o_wrap", o_wrap, '0);
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_vec($sformatf("o_clk step %0d", e.id), o_clk, e.clk);
        check_vec($sformatf("o_pend step %0d", e.id), o_pend, e.pend);
        check_vec($sformatf("o_wrap step %0d", e.id), o_wrap, e.wrap);
      end
    end
  end

  initial begin : stimulus
    int unsigned         tw;
    logic [CHANNELS-1:0] en;
    model_reset();
    do_reset();

    // Idle after reset: zero words, nothing moves.
    idle(5, 4'hF);

    // Four channels at 0x2000, 0x8000, 0xFFFF, 0x4000.
    step(1, 0, 16'h2000, 4'hF);
    step(1, 1, 16'h8000, 4'hF);
    step(1, 2, 16'hFFFF, 4'hF);
    step(1, 3, 16'h4000, 4'hF);
    idle(30, 4'hF);

    // Mid-period retune of ch0, then two back-to-back loads on ch3.
    idle(3, 4'hF);
    step(1, 0, 16'h1000, 4'hF);
    idle(20, 4'hF);
    step(1, 3, 16'h1000, 4'hF);
    step(1, 3, 16'h0800, 4'hF);
    idle(70, 4'hF);

    // Disabled channel keeps its pending word and phase.
    step(1, 1, 16'h2000, 4'b1101);
    idle(10, 4'b1101);
    idle(20, 4'hF);

    // Zero word stops ch0 at its next wrap.
    step(1, 0, 16'h0000, 4'hF);
    idle(40, 4'hF);

    // Reset with a word pending, then nothing should run.
    step(1, 2, 16'h3000, 4'hF);
    do_reset();
    idle(20, 4'hF);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CHANNELS; c++) en[c] = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       tw = $urandom_range(0, 65535);
        1:       tw = 32'h1000 << $urandom_range(0, 3);
        2:       tw = $urandom_range(0, 1) ? 0 : 16'hFFFF;
        default: tw = $urandom_range(1, 2047);
      endcase
      step($urandom_range(0, 7) == 0, $urandom_range(0, CHANNELS - 1), tw, en);
      if (i == 1500) begin
        do_reset();
      end
    end

    @(negedge i_clk);
    i_load = 0;
    i_en   = '0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge i_clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
